// File: rtl/branch_pred_unit.sv
// Branch prediction unit: direct-mapped BTB with 2-bit saturating counters,
// combinational fetch lookup, EX-stage resolution/mispredict detection and
// performance counters.
module branch_pred_unit #(
    parameter int PC_W    = 9,
    parameter int ENTRIES = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [PC_W-1:0] if_pc,
    output logic            pred_taken,
    output logic [31:0]     pred_target,
    input  logic            ex_valid,
    input  logic            ex_branch,
    input  logic            ex_jump,
    input  logic            ex_jalr,
    input  logic [PC_W-1:0] ex_pc,
    input  logic [31:0]     ex_imm,
    input  logic [31:0]     ex_alu_result,
    input  logic            ex_pred_taken,
    input  logic [31:0]     ex_pred_target,
    output logic [31:0]     pc_imm,
    output logic [31:0]     pc_four,
    output logic [31:0]     br_pc,
    output logic            pc_sel,
    output logic            mispredict,
    output logic [31:0]     br_count,
    output logic [31:0]     miss_count
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - IDX_W - 2;

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];

    logic [IDX_W-1:0] if_idx;
    logic [TAG_W-1:0] if_tag;
    logic [IDX_W-1:0] ex_idx;
    logic [TAG_W-1:0] ex_tag;
    logic             if_hit;
    logic             ex_hit;
    logic [31:0]      pc_full;
    logic             resolve;
    logic             actual_taken;
    logic [31:0]      actual_target;

    // Word-aligned PC bits [1:0] never select an entry.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_pc[1:0], ex_pc[1:0]};

    assign if_idx = if_pc[IDX_W+1:2];
    assign if_tag = if_pc[PC_W-1:IDX_W+2];
    assign ex_idx = ex_pc[IDX_W+1:2];
    assign ex_tag = ex_pc[PC_W-1:IDX_W+2];

    // Fetch-side lookup: reads pre-edge table contents, no update bypass.
    always_comb begin
        if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
        pred_taken  = if_hit && ctr_q[if_idx][1];
        pred_target = if_hit ? target_q[if_idx] : '0;
    end

    // EX-side resolution: actual outcome, redirect target and mispredict.
    always_comb begin
        pc_full       = 32'(ex_pc);
        pc_imm        = pc_full + ex_imm;
        pc_four       = pc_full + 32'd4;
        resolve       = ex_valid && (ex_branch || ex_jump);
        actual_taken  = ex_jump || (ex_branch && ex_alu_result[0]);
        actual_target = ex_jalr ? {ex_alu_result[31:1], 1'b0} : pc_imm;
        ex_hit        = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
        mispredict    = resolve &&
                        ((actual_taken != ex_pred_taken) ||
                         (actual_taken && (ex_pred_target != actual_target)));
        pc_sel        = mispredict;
        br_pc         = actual_taken ? actual_target : pc_four;
    end

    // Table training/allocation and performance counters; reset wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid_q[IDX_W'(i)]  <= 1'b0;
                tag_q[IDX_W'(i)]    <= '0;
                target_q[IDX_W'(i)] <= '0;
                ctr_q[IDX_W'(i)]    <= 2'b01;
            end
            br_count   <= '0;
            miss_count <= '0;
        end else if (resolve) begin
            br_count <= br_count + 32'd1;
            if (mispredict) begin
                miss_count <= miss_count + 32'd1;
            end
            if (ex_hit) begin
                if (actual_taken) begin
                    if (ctr_q[ex_idx] != 2'b11) begin
                        ctr_q[ex_idx] <= ctr_q[ex_idx] + 2'd1;
                    end
                    target_q[ex_idx] <= actual_target;
                end else if (ctr_q[ex_idx] != 2'b00) begin
                    ctr_q[ex_idx] <= ctr_q[ex_idx] - 2'd1;
                end
            end else if (actual_taken) begin
                valid_q[ex_idx]  <= 1'b1;
                tag_q[ex_idx]    <= ex_tag;
                target_q[ex_idx] <= actual_target;
                ctr_q[ex_idx]    <= 2'b10;
            end
        end
    end

endmodule

// File: tb/tb_branch_pred_unit.sv
// Directed, table-driven bench for branch_pred_unit (PC_W=9, ENTRIES=16).
module tb_branch_pred_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [8:0]  if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid, ex_branch, ex_jump, ex_jalr;
    logic [8:0]  ex_pc;
    logic [31:0] ex_imm, ex_alu_result;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic [31:0] pc_imm, pc_four, br_pc;
    logic        pc_sel, mispredict;
    logic [31:0] br_count, miss_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_pred_unit #(.PC_W(9), .ENTRIES(16)) dut (
        .clk(clk), .reset(reset), .if_pc(if_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_jalr(ex_jalr),
        .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_alu_result(ex_alu_result),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .pc_imm(pc_imm), .pc_four(pc_four), .br_pc(br_pc),
        .pc_sel(pc_sel), .mispredict(mispredict),
        .br_count(br_count), .miss_count(miss_count)
    );

    typedef struct {
        logic        rst;
        logic [8:0]  ipc;
        logic        v, br, jmp, jalr;
        logic [8:0]  pc;
        logic [31:0] imm, alu;
        logic        pt;
        logic [31:0] ptgt;
        logic        chk;
        logic        e_pt;
        logic [31:0] e_ptgt;
        logic        e_misp;
        logic        chk_bpc;
        logic [31:0] e_bpc, e_brc, e_miss;
    } vec_t;

    localparam int NV = 26;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        reset          = t.rst;
        if_pc          = t.ipc;
        ex_valid       = t.v;
        ex_branch      = t.br;
        ex_jump        = t.jmp;
        ex_jalr        = t.jalr;
        ex_pc          = t.pc;
        ex_imm         = t.imm;
        ex_alu_result  = t.alu;
        ex_pred_taken  = t.pt;
        ex_pred_target = t.ptgt;
    endtask

    // Resolve a conditional branch at 0x100 (imm 8) and check mispredict.
    task automatic res_0x100(input logic pt, input logic [31:0] ptgt, input logic alu0,
                             input logic e_misp, input string name);
        @(negedge clk);
        drive('{1'b0, 9'h100, 1'b1, 1'b1, 1'b0, 1'b0, 9'h100, 32'h8, {31'd0, alu0}, pt, ptgt,
                1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0});
        #1;
        check({name, ".mispredict"}, {31'd0, mispredict}, {31'd0, e_misp});
    endtask

    task automatic look(input logic [8:0] pc, input logic e_pt, input logic [31:0] e_tgt,
                        input string name);
        @(negedge clk);
        drive('{1'b0, pc, 1'b0, 1'b0, 1'b0, 1'b0, 9'h0, 32'h0, 32'h0, 1'b0, 32'h0,
                1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0});
        #1;
        check({name, ".pred_taken"}, {31'd0, pred_taken}, {31'd0, e_pt});
        check({name, ".pred_target"}, pred_target, e_tgt);
    endtask

    initial begin
        // rst ipc v br j jalr pc imm alu pt ptgt | chk ept eptgt emisp chkb ebpc brc miss
        vecs[0]  = '{1, 9'h040, 0,0,0,0, 9'h000, 32'h0, 32'h0, 0, 32'h0,   0, 0, 32'h0,   0, 0, 32'h0,   0, 0};
        vecs[1]  = '{0, 9'h040, 0,0,0,0, 9'h000, 32'h0, 32'h0, 0, 32'h0,   1, 0, 32'h0,   0, 0, 32'h0,   0, 0};
        vecs[2]  = '{0, 9'h040, 1,1,0,0, 9'h040, 32'h20, 32'h1, 0, 32'h0,  1, 0, 32'h0,   1, 1, 32'h60,  0, 0};
        vecs[3]  = '{0, 9'h040, 0,0,0,0, 9'h000, 32'h0, 32'h0, 0, 32'h0,   1, 1, 32'h60,  0, 0, 32'h0,   1, 1};
        vecs[4]  = '{0, 9'h040, 1,1,0,0, 9'h040, 32'h20, 32'h0, 1, 32'h60, 1, 1, 32'h60,  1, 1, 32'h44,  1, 1};
        vecs[5]  = '{0, 9'h040, 1,1,0,0, 9'h040, 32'h20, 32'h0, 0, 32'h0,  1, 0, 32'h60,  0, 1, 32'h44,  2, 2};
        vecs[6]  = '{0, 9'h040, 0,0,0,0, 9'h000, 32'h0, 32'h0, 0, 32'h0,   1, 0, 32'h60,  0, 0, 32'h0,   3, 2};
        vecs[7]  = '{0, 9'h140, 1,1,0,0, 9'h140, 32'h10, 32'h1, 0, 32'h0,  1, 0, 32'h0,   1, 1, 32'h150, 3, 2};
        vecs[8]  = '{0, 9'h040, 0,0,0,0, 9'h000, 32'h0, 32'h0, 0, 32'h0,   1, 0, 32'h0,   0, 0, 32'h0,   4, 3};
        vecs[9]  = '{0, 9'h140, 0,0,0,0, 9'h000, 32'h0, 32'h0, 0, 32'h0,   1, 1, 32'h150, 0, 0, 32'h0,   4, 3};
        vecs[10] = '{0, 9'h140, 1,0,1,1, 9'h084, 32'h0, 32'h123, 1, 32'h122, 1, 1, 32'h150, 0, 1, 32'h122, 4, 3};
        vecs[11] = '{0, 9'h084, 1,0,1,1, 9'h084, 32'h0, 32'h123, 1, 32'h120, 1, 1, 32'h122, 1, 1, 32'h122, 5, 3};
        vecs[12] = '{0, 9'h084, 0,0,0,0, 9'h000, 32'h0, 32'h0, 0, 32'h0,   1, 1, 32'h122, 0, 0, 32'h0,   6, 4};
        vecs[13] = '{0, 9'h0C8, 1,1,0,0, 9'h0C8, 32'h10, 32'h0, 0, 32'h0,  1, 0, 32'h0,   0, 1, 32'hCC,  6, 4};
        vecs[14] = '{0, 9'h0C8, 0,0,0,0, 9'h000, 32'h0, 32'h0, 0, 32'h0,   1, 0, 32'h0,   0, 0, 32'h0,   7, 4};
        vecs[15] = '{0, 9'h0C8, 0,1,0,0, 9'h0C8, 32'h10, 32'h1, 0, 32'h0,  1, 0, 32'h0,   0, 0, 32'h0,   7, 4};
        vecs[16] = '{0, 9'h0C8, 0,0,0,0, 9'h000, 32'h0, 32'h0, 0, 32'h0,   1, 0, 32'h0,   0, 0, 32'h0,   7, 4};
        vecs[17] = '{0, 9'h1FC, 1,0,1,0, 9'h1FC, 32'hFFFFFFF0, 32'h0, 0, 32'h0, 1, 0, 32'h0, 1, 1, 32'h1EC, 7, 4};
        vecs[18] = '{0, 9'h1FC, 0,0,0,0, 9'h000, 32'h0, 32'h0, 0, 32'h0,   1, 1, 32'h1EC, 0, 0, 32'h0,   8, 5};
        vecs[19] = '{0, 9'h084, 1,1,0,0, 9'h084, 32'h10, 32'h1, 1, 32'h94, 1, 1, 32'h122, 0, 1, 32'h94,  8, 5};
        vecs[20] = '{0, 9'h084, 1,1,0,0, 9'h084, 32'h10, 32'h0, 1, 32'h94, 1, 1, 32'h94,  1, 1, 32'h88,  9, 5};
        vecs[21] = '{0, 9'h084, 0,0,0,0, 9'h000, 32'h0, 32'h0, 0, 32'h0,   1, 1, 32'h94,  0, 0, 32'h0,  10, 6};
        vecs[22] = '{1, 9'h040, 1,1,0,0, 9'h040, 32'h20, 32'h1, 0, 32'h0,  1, 0, 32'h0,   1, 1, 32'h60, 10, 6};
        vecs[23] = '{0, 9'h040, 0,0,0,0, 9'h000, 32'h0, 32'h0, 0, 32'h0,   1, 0, 32'h0,   0, 0, 32'h0,   0, 0};
        vecs[24] = '{0, 9'h084, 0,0,0,0, 9'h000, 32'h0, 32'h0, 0, 32'h0,   1, 0, 32'h0,   0, 0, 32'h0,   0, 0};
        vecs[25] = '{0, 9'h1FC, 0,0,0,0, 9'h000, 32'h0, 32'h0, 0, 32'h0,   1, 0, 32'h0,   0, 0, 32'h0,   0, 0};

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            if (vecs[i].chk) begin
                check($sformatf("v%0d.pred_taken", i), {31'd0, pred_taken}, {31'd0, vecs[i].e_pt});
                check($sformatf("v%0d.pred_target", i), pred_target, vecs[i].e_ptgt);
                check($sformatf("v%0d.mispredict", i), {31'd0, mispredict}, {31'd0, vecs[i].e_misp});
                check($sformatf("v%0d.pc_sel", i), {31'd0, pc_sel}, {31'd0, vecs[i].e_misp});
                check($sformatf("v%0d.pc_four", i), pc_four, 32'(vecs[i].pc) + 32'd4);
                check($sformatf("v%0d.pc_imm", i), pc_imm, 32'(vecs[i].pc) + vecs[i].imm);
                check($sformatf("v%0d.br_count", i), br_count, vecs[i].e_brc);
                check($sformatf("v%0d.miss_count", i), miss_count, vecs[i].e_miss);
                if (vecs[i].chk_bpc)
                    check($sformatf("v%0d.br_pc", i), br_pc, vecs[i].e_bpc);
            end
        end

        // Counter walk on a fresh entry at 0x100: allocate, saturate high, decay.
        res_0x100(1'b0, 32'h0,   1'b1, 1'b1, "walk.alloc");
        look(9'h100, 1'b1, 32'h108, "walk.after_alloc");
        res_0x100(1'b1, 32'h108, 1'b1, 1'b0, "walk.inc3");
        res_0x100(1'b1, 32'h108, 1'b1, 1'b0, "walk.sat3");
        res_0x100(1'b1, 32'h108, 1'b0, 1'b1, "walk.dec2");
        look(9'h100, 1'b1, 32'h108, "walk.ctr2");
        res_0x100(1'b1, 32'h108, 1'b0, 1'b1, "walk.dec1");
        look(9'h100, 1'b0, 32'h108, "walk.ctr1");
        check("walk.br_count", br_count, 32'd5);
        check("walk.miss_count", miss_count, 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/branch_pred_unit.md
BRANCH_PRED_UNIT -- requirements
Module: branch_pred_unit

Interface
REQ-001 SHALL have parameter PC_W, default 9: PC width in bits.
REQ-002 SHALL have parameter ENTRIES, default 16: predictor table depth, power of two; IDX_W = log2(ENTRIES); PC_W >= IDX_W+3.
REQ-003 SHALL have ports clk (input, 1) and reset (input, 1): one clock; reset is synchronous and active-high.
REQ-004 SHALL have port if_pc (input, PC_W): fetch-stage PC for lookup.
REQ-005 SHALL have ports pred_taken (output, 1) and pred_target (output, 32): fetch prediction.
REQ-006 SHALL have ports ex_valid, ex_branch, ex_jump and ex_jalr (input, 1 each): EX-stage qualifiers.
REQ-007 SHALL have ports ex_pc (input, PC_W), ex_imm (input, 32) and ex_alu_result (input, 32).
REQ-008 SHALL have ports ex_pred_taken (input, 1) and ex_pred_target (input, 32): prediction made for the EX instruction, piped from fetch.
REQ-009 SHALL have ports pc_imm, pc_four and br_pc (output, 32 each).
REQ-010 SHALL have ports pc_sel and mispredict (output, 1 each).
REQ-011 SHALL have ports br_count and miss_count (output, 32 each): performance counters.

Function
REQ-012 Table entry SHALL hold valid (1b), tag (PC_W-IDX_W-2 b), target (32b) and ctr (2b saturating counter).
REQ-013 Index SHALL be pc[IDX_W+1:2]; tag SHALL be pc[PC_W-1:IDX_W+2].
REQ-014 Lookup SHALL be combinational: hit = valid && tag match at if_pc; pred_taken = hit && ctr[1]; pred_target = hit ? stored target : 0.
REQ-015 pc_full SHALL be ex_pc zero-extended to 32 bits; pc_imm = pc_full + ex_imm; pc_four = pc_full + 4; all additions SHALL wrap mod 2^32.
REQ-016 resolve SHALL be ex_valid && (ex_branch || ex_jump).
REQ-017 actual_taken SHALL be ex_jump || (ex_branch && ex_alu_result[0]).
REQ-018 actual_target SHALL be {ex_alu_result[31:1],1'b0} when ex_jalr, else pc_imm.
REQ-019 mispredict SHALL be resolve && (actual_taken != ex_pred_taken || (actual_taken && ex_pred_target != actual_target)), combinational.
REQ-020 pc_sel SHALL equal mispredict.
REQ-021 br_pc SHALL be actual_taken ? actual_target : pc_four; br_pc is don't-care when pc_sel=0.
REQ-022 On a clk edge with resolve and an ex_pc hit: ctr SHALL increment when actual_taken and decrement when not, saturating at 3 and 0; target SHALL be written with actual_target when actual_taken.
REQ-023 On a clk edge with resolve, ex_pc miss and actual_taken: the entry SHALL be allocated (replacing any valid entry) with valid=1, tag, target=actual_target and ctr=2.
REQ-024 On resolve with a miss and not taken, the table SHALL be unchanged.
REQ-025 Simultaneous lookup and update of the same index: lookup SHALL return the pre-edge contents; there is no bypass.
REQ-026 br_count SHALL increment by 1 per resolve cycle and miss_count by 1 per mispredict cycle; both SHALL wrap at 2^32.
REQ-027 With resolve=0, no table or counter state SHALL change; mispredict and pc_sel SHALL be 0.

Reset
REQ-028 reset SHALL clear all valid bits, set all ctr to 1 (weakly not-taken), and zero targets, tags, br_count and miss_count on the clk edge.
REQ-029 reset SHALL take priority over any simultaneous update.
REQ-030 After reset, pred_taken SHALL be 0 and pred_target 0x0 for any if_pc.

Verification (PC_W=9, ENTRIES=16)
REQ-031 Reset, then lookup with if_pc=0x040 -> pred_taken=0, pred_target=0, br_count=0, miss_count=0.
REQ-032 Resolve a taken branch with ex_pc=0x040, ex_imm=0x20, alu[0]=1, ex_pred_taken=0 -> mispredict=1, pc_sel=1, br_pc=0x060; next cycle, if_pc=0x040 -> pred_taken=1, pred_target=0x060, miss_count=1.
REQ-033 Resolve the same branch not taken twice (pred 1, then pred 0) -> first: mispredict=1, br_pc=0x044, ctr=1, prediction becomes 0; second: mispredict=0, ctr=0, br_count=3.
REQ-034 Alias case: after REQ-032, lookup if_pc=0x140 (same index, different tag) -> pred_taken=0; a taken resolve at 0x140 replaces the entry, and 0x040 then misses.
REQ-035 Resolve JALR with ex_alu_result=0x123 and ex_pred_target=0x122 predicted taken -> mispredict=0; with ex_pred_target=0x120 -> mispredict=1, br_pc=0x122.
REQ-036 Assert reset in the same cycle as a taken resolve -> no allocation; table cleared; counters 0.
